data_memory_stage: RTL

Pipeline MEM stage of the RV32I core: receives the EXE stage's instruction and ALU result, performs LOAD/STORE accesses against an internal word-organised data RAM, and registers the instruction and result for the write-back controller. For non-memory instructions it passes the ALU result through unchanged, so write-back always takes its register data from `mem_result`.

---
 rtl/data_memory_stage.sv | 86 ++++++++
 1 files changed

// File: rtl/data_memory_stage.sv
// RV32I MEM stage: byte-lane LOAD/STORE against an internal word RAM, with a 1-cycle
// registered hand-off of instruction, result and alignment/funct3 fault to write-back.
module data_memory_stage #(
   parameter int ADDR_W = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] exe_inst,
   input  logic [31:0] exe_result,
   input  logic [31:0] exe_rs2_data,
   output logic [31:0] mem_inst,
   output logic [31:0] mem_result,
   output logic        mem_fault
);
   localparam int         DEPTH    = 1 << ADDR_W;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   logic [31:0]       ram [DEPTH];
   logic              is_load, is_store, fault, wr_en;
   logic [2:0]        funct3;
   logic [1:0]        lane;
   logic [ADDR_W-1:0] idx;
   logic [31:0]       rd_word, load_data, wr_data;
   logic [7:0]        b_sel;
   logic [15:0]       h_sel;
   logic [3:0]        wr_be;

   assign is_load  = (exe_inst[6:0] == OP_LOAD);
   assign is_store = (exe_inst[6:0] == OP_STORE);
   assign funct3   = exe_inst[14:12];
   assign lane     = exe_result[1:0];
   assign idx      = exe_result[ADDR_W+1:2];
   assign rd_word  = ram[idx];
   assign b_sel    = rd_word[{lane, 3'b000} +: 8];
   assign h_sel    = lane[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      load_data = '0;
      wr_data   = exe_rs2_data;
      wr_be     = 4'b0000;
      fault     = 1'b0;
      if (is_load) begin
         case (funct3)
            3'b000:  load_data = {{24{b_sel[7]}}, b_sel};
            3'b100:  load_data = {24'h0, b_sel};
            3'b001:  begin load_data = {{16{h_sel[15]}}, h_sel}; fault = lane[0]; end
            3'b101:  begin load_data = {16'h0, h_sel};           fault = lane[0]; end
            3'b010:  begin load_data = rd_word;                  fault = (lane != 2'b00); end
            default: fault = 1'b1;
         endcase
      end else if (is_store) begin
         // Store data is replicated across lanes; the byte enables pick the live ones.
         case (funct3)
            3'b000:  begin wr_data = {4{exe_rs2_data[7:0]}};  wr_be = 4'b0001 << lane; end
            3'b001:  begin wr_data = {2{exe_rs2_data[15:0]}}; wr_be = lane[1] ? 4'b1100 : 4'b0011;
                           fault = lane[0]; end
            3'b010:  begin wr_be = 4'b1111; fault = (lane != 2'b00); end
            default: fault = 1'b1;
         endcase
      end
   end

   assign wr_en = is_store && !fault && !rst;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) ram[idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_inst   <= '0;
         mem_result <= '0;
         mem_fault  <= 1'b0;
      end else begin
         mem_inst   <= exe_inst;
         mem_result <= (is_load && !fault) ? load_data :
                       is_load             ? 32'h0     : exe_result;
         mem_fault  <= fault;
      end
   end
endmodule
